uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter fed by a small transmit FIFO. Frames are
//               start + DATA_BITS (LSB first) + optional parity + stop bit(s),
//               each bit held for CLK_DIV cycles of clk_fpga.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_fpga,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          wr_en,
    output logic                          tx,
    output logic                          busy,
    output logic                          flag,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_TW = $clog2(CLK_DIV);

    localparam logic [c_LW-1:0] c_DEPTH     = c_LW'(FIFO_DEPTH);
    localparam logic [c_TW-1:0] c_T_LAST    = c_TW'(CLK_DIV - 1);
    localparam logic [c_TW-1:0] c_T_PRELAST = c_TW'(CLK_DIV - 2);
    localparam logic [3:0]      c_D_LAST    = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_S_LAST    = 4'(STOP_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_LW-1:0]      r_level;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_overflow;

    // Transmit engine
    logic [2:0]           r_state;
    logic [c_TW-1:0]      r_timer;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_flag;

    logic                 w_bit_end;
    logic                 w_frame_end;
    logic                 w_push;
    logic                 w_pop;
    logic [c_LW-1:0]      w_level_nxt;

    assign w_bit_end   = (r_timer == c_T_LAST);
    assign w_frame_end = (r_state == c_ST_STOP) && w_bit_end && (r_bit == c_S_LAST);
    // A pop happens whenever the engine is free to start a frame: from IDLE,
    // or on the final stop cycle so frames run back to back.
    assign w_pop       = !r_empty && ((r_state == c_ST_IDLE) || w_frame_end);
    // Writes during reset or into a full FIFO are dropped; full uses the
    // pre-edge count so a simultaneous pop does not rescue the write.
    assign w_push      = wr_en && !r_full && !rst;

    // Next occupancy: a simultaneous push and pop leaves the level unchanged
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_LW'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - c_LW'(1);
        end
    end

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk_fpga) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    // Pointers, registered level/status flags and the overflow pulse
    always_ff @(posedge clk_fpga) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && r_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_DEPTH);
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Frame sequencer; tx/busy/flag are registered alongside the state
    always_ff @(posedge clk_fpga) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_timer  <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_flag   <= 1'b0;
        end else begin
            // Flag is raised one edge early so it is high during the last stop cycle
            r_flag <= (r_state == c_ST_STOP) && (r_bit == c_S_LAST) && (r_timer == c_T_PRELAST);
            if (r_state != c_ST_IDLE) begin
                r_timer <= w_bit_end ? '0 : r_timer + c_TW'(1);
            end
            case (r_state)
                c_ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    r_timer <= '0;
                    if (w_pop) begin
                        r_shift  <= r_mem[r_rd_ptr];
                        r_parity <= (^r_mem[r_rd_ptr]) ^ (PARITY == 2);
                        r_state  <= c_ST_START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_state <= c_ST_DATA;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == c_D_LAST) begin
                            r_bit <= '0;
                            if (PARITY != 0) begin
                                r_state <= c_ST_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= c_ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + 4'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                end
                c_ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= c_ST_STOP;
                        r_bit   <= '0;
                        r_tx    <= 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit == c_S_LAST) begin
                            r_bit <= '0;
                            if (w_pop) begin
                                r_shift  <= r_mem[r_rd_ptr];
                                r_parity <= (^r_mem[r_rd_ptr]) ^ (PARITY == 2);
                                r_state  <= c_ST_START;
                                r_tx     <= 1'b0;
                            end else begin
                                r_state <= c_ST_IDLE;
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign flag       = r_flag;
    assign fifo_full  = r_full;
    assign fifo_empty = r_empty;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
